counter_bus_host: RTL and testbench

Host-side controller for the 8-bit loadable counter tile's bus: it turns single-word write/read commands into the counter's load_n / output_enable_n strobes and drives or samples the shared bidirectional data bus. It sits between on-chip control logic and the counter pins. It guarantees the bus is never actively driven from both ends on a clock edge, and it returns sampled counter values on a response port.

---
 rtl/counter_host_pkg.sv | 21 ++
 rtl/counter_bus_host_if.sv | 31 +++
 rtl/counter_bus_host.sv | 99 +++++++++
 tb/tb_counter_bus_host.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_host_pkg.sv
// Shared types and constants for the counter bus host.
// COUNTER_HOST_VERIFY_EN adds the write read-back state and one cycle of write latency.
package counter_host_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_DRIVE   = 3'd1,
    WR_RELEASE = 3'd2,
    RD         = 3'd3,
    VERIFY     = 3'd4
  } state_t;

`ifdef COUNTER_HOST_VERIFY_EN
  localparam int unsigned HOST_WR_LATENCY = 3;
`else
  localparam int unsigned HOST_WR_LATENCY = 2;
`endif

endpackage

// File: rtl/counter_bus_host_if.sv
// Command/response handshake plus counter pin bundle for the counter bus host.
// slave is the host block's view; master is the control-logic / pin side.
interface counter_bus_host_if;
  import counter_host_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             load_n;
  logic             oe_n;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] bus_oe;
  logic [WIDTH-1:0] bus_in;

  modport slave (
    input  cmd_valid, cmd_write, cmd_data, bus_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output load_n, oe_n, bus_out, bus_oe
  );

  modport master (
    output cmd_valid, cmd_write, cmd_data, bus_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  load_n, oe_n, bus_out, bus_oe
  );

endinterface

// File: rtl/counter_bus_host.sv
// Turns single-word write/read commands into counter load_n/oe_n strobes and bus drive.
// Define COUNTER_HOST_VERIFY_EN to read back every write and flag mismatches on rsp_err.
module counter_bus_host
  import counter_host_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  counter_bus_host_if.slave  bus
);

  state_t           state;
  logic [WIDTH-1:0] wdata;

`ifdef COUNTER_HOST_VERIFY_EN
  // Counter loads wdata, then increments once while the bus floats.
  logic [WIDTH-1:0] expect_c;
  assign expect_c = wdata + WIDTH'(1);
`endif

  // Single registered FSM; every strobe is the value for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wdata         <= '0;
      bus.load_n    <= 1'b1;
      bus.oe_n      <= 1'b1;
      bus.bus_oe    <= '0;
      bus.bus_out   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.cmd_ready <= 1'b1;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (bus.cmd_write) begin
              state       <= WR_DRIVE;
              wdata       <= bus.cmd_data;
              bus.load_n  <= 1'b0;
              bus.bus_oe  <= '1;
              bus.bus_out <= bus.cmd_data;
            end else begin
              state    <= RD;
              bus.oe_n <= 1'b0;
            end
          end
        end
        WR_DRIVE: begin
          // Release the bus while load_n stays low so neither end drives it.
          state      <= WR_RELEASE;
          bus.load_n <= 1'b0;
          bus.bus_oe <= '0;
        end
        WR_RELEASE: begin
          bus.load_n <= 1'b1;
`ifdef COUNTER_HOST_VERIFY_EN
          state      <= VERIFY;
          bus.oe_n   <= 1'b0;
`else
          state         <= IDLE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= wdata;
          bus.rsp_err   <= 1'b0;
          bus.cmd_ready <= 1'b1;
`endif
        end
        RD: begin
          state         <= IDLE;
          bus.oe_n      <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= bus.bus_in;
          bus.rsp_err   <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
`ifdef COUNTER_HOST_VERIFY_EN
        VERIFY: begin
          state         <= IDLE;
          bus.oe_n      <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= bus.bus_in;
          bus.rsp_err   <= (bus.bus_in != expect_c);
          bus.cmd_ready <= 1'b1;
        end
`endif
        default: begin
          state         <= IDLE;
          bus.load_n    <= 1'b1;
          bus.oe_n      <= 1'b1;
          bus.bus_oe    <= '0;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_bus_host.sv
// Bench for counter_bus_host: counter tile model on the shared bus, cycle-level
// transaction scoreboard, and directed write/read/back-to-back/reset scenarios.
module tb_counter_bus_host;
  import counter_host_pkg::*;

`ifdef COUNTER_HOST_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
  localparam int WR_LAT    = 3;
`else
  localparam bit VERIFY_ON = 1'b0;
  localparam int WR_LAT    = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_bus_host_if bif();
  counter_bus_host dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Counter tile model: loads on a falling load_n, otherwise increments every edge.
  logic [7:0] cnt = 8'h00;
  logic       prev_load_n = 1'b1;
  logic [7:0] stuck_mask = 8'hFF;
  logic       cnt_drv, host_drv;
  logic [7:0] bus_val;

  always_comb begin
    cnt_drv  = bif.load_n | ~bif.oe_n;
    host_drv = |bif.bus_oe;
    bus_val  = cnt_drv ? cnt : (host_drv ? bif.bus_out : 8'h00);
    bus_val  = bus_val & stuck_mask;
  end
  assign bif.bus_in = bus_val;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         cyc = 0;
  int         drive_cyc = -10;
  int         oe_cyc = -10;
  logic [7:0] drive_data = 8'h00;
  logic [7:0] rb, inc;
  bit         model_ready;
  int         rsp_count = 0;

  // Transaction model: predicts response cycle/value and strobe cycles on acceptance.
  always @(posedge clk) begin
    model_ready = (q.size() == 0) || (q[0].due == cyc);
    if (rst_n && bif.cmd_valid && model_ready) begin
      if (bif.cmd_write) begin
        e.due      = cyc + 1 + WR_LAT;
        drive_cyc  = cyc + 1;
        drive_data = bif.cmd_data;
        if (VERIFY_ON) begin
          inc    = bif.cmd_data + 8'd1;
          rb     = ((bif.cmd_data & stuck_mask) + 8'd1) & stuck_mask;
          e.data = rb;
          e.err  = (rb != inc);
          oe_cyc = cyc + 3;
        end else begin
          e.data = bif.cmd_data;
          e.err  = 1'b0;
        end
      end else begin
        e.due  = cyc + 2;
        e.data = (cnt + 8'd1) & stuck_mask;
        e.err  = 1'b0;
        oe_cyc = cyc + 1;
      end
      q.push_back(e);
    end
    if (!bif.load_n && prev_load_n) cnt = bus_val;
    else                            cnt = cnt + 8'd1;
    prev_load_n = bif.load_n;
    cyc++;
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      drive_cyc = -10;
      oe_cyc    = -10;
      chk("rst_load_n", 32'(bif.load_n), 32'd1);
      chk("rst_oe_n", 32'(bif.oe_n), 32'd1);
      chk("rst_bus_oe", 32'(bif.bus_oe), 32'd0);
      chk("rst_bus_out", 32'(bif.bus_out), 32'd0);
      chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bif.rsp_data), 32'd0);
      chk("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
    end else begin
      automatic bit exp_valid = (q.size() > 0) && (q[0].due == cyc);
      chk("rsp_valid", 32'(bif.rsp_valid), 32'(exp_valid));
      chk("cmd_ready", 32'(bif.cmd_ready), 32'((q.size() == 0) || exp_valid));
      if (exp_valid) begin
        chk("rsp_data", 32'(bif.rsp_data), 32'(q[0].data));
        chk("rsp_err", 32'(bif.rsp_err), 32'(q[0].err));
        void'(q.pop_front());
      end
      chk("bus_oe", 32'(bif.bus_oe), (cyc == drive_cyc) ? 32'hFF : 32'h00);
      if (cyc == drive_cyc) chk("bus_out", 32'(bif.bus_out), 32'(drive_data));
      chk("load_n", 32'(bif.load_n), 32'(!(cyc == drive_cyc || cyc == drive_cyc + 1)));
      chk("oe_n", 32'(bif.oe_n), 32'(cyc != oe_cyc));
      chk("two_driver", 32'(cnt_drv && host_drv), 32'd0);
    end
    if (bif.rsp_valid) rsp_count++;
  end

  // Offer a command at a negedge; return at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [7:0] d, input bit hold);
    int n = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_data  = d;
    while (!bif.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    if (!hold) begin
      bif.cmd_valid = 1'b0;
      bif.cmd_data  = 8'($urandom);
    end
  endtask

  task automatic wait_rsp(output logic [7:0] d, output logic er, output int n);
    n = 0;
    while (!bif.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rsp_timeout", 32'd1, 32'd0);
    d  = bif.rsp_data;
    er = bif.rsp_err;
    @(negedge clk);
  endtask

  logic [7:0] d;
  logic       er;
  int         n;
  int         base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Write 5A: drive one cycle, float one cycle, counter holds 5A then 5B.
    issue(1'b1, 8'h5A, 1'b0);
    chk("w5a_drive_oe", 32'(bif.bus_oe), 32'hFF);
    chk("w5a_drive_out", 32'(bif.bus_out), 32'h5A);
    @(negedge clk);
    chk("w5a_release_oe", 32'(bif.bus_oe), 32'h00);
    chk("w5a_loaded", 32'(cnt), 32'h5A);
    @(negedge clk);
    chk("w5a_incremented", 32'(cnt), 32'h5B);
    wait_rsp(d, er, n);
    chk("w5a_latency", 32'(n + 2), 32'(WR_LAT));
    chk("w5a_rsp_data", 32'(d), VERIFY_ON ? 32'h5B : 32'h5A);
    chk("w5a_rsp_err", 32'(er), 32'd0);

    // Write FF wraps to 00 on read-back.
    issue(1'b1, 8'hFF, 1'b0);
    wait_rsp(d, er, n);
    chk("wff_rsp_data", 32'(d), VERIFY_ON ? 32'h00 : 32'hFF);
    chk("wff_rsp_err", 32'(er), 32'd0);

    // Bus bit 0 stuck low: load 5A, increments to 5B, read back 5A.
    stuck_mask = 8'hFE;
    issue(1'b1, 8'h5A, 1'b0);
    wait_rsp(d, er, n);
    chk("stuck_rsp_data", 32'(d), 32'h5A);
    chk("stuck_rsp_err", 32'(er), VERIFY_ON ? 32'd1 : 32'd0);
    stuck_mask = 8'hFF;

    // Read: counter preset so it holds 10 during the RD cycle.
    cnt = 8'h0F;
    issue(1'b0, 8'h00, 1'b0);
    wait_rsp(d, er, n);
    chk("rd_latency", 32'(n), 32'd1);
    chk("rd_rsp_data", 32'(d), 32'h10);
    chk("rd_rsp_err", 32'(er), 32'd0);
    chk("rd_pulse_width", 32'(bif.rsp_valid), 32'd0);

    // Back-to-back: cmd_valid stays high from a write into a read.
    repeat (2) @(negedge clk);
    #1 base = rsp_count;
    @(negedge clk);
    issue(1'b1, 8'hC3, 1'b1);
    issue(1'b0, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    #1 chk("b2b_rsp_count", 32'(rsp_count - base), 32'd2);

    // Async reset during WR_DRIVE releases the bus immediately.
    @(negedge clk);
    issue(1'b1, 8'h33, 1'b0);
    chk("ar_pre_oe", 32'(bif.bus_oe), 32'hFF);
    #1 base = rsp_count;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_bus_oe", 32'(bif.bus_oe), 32'h00);
    chk("ar_load_n", 32'(bif.load_n), 32'd1);
    chk("ar_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("ar_no_rsp", 32'(rsp_count - base), 32'd0);

    // Normal operation after reset release.
    @(negedge clk);
    cnt = 8'h7E;
    issue(1'b0, 8'h00, 1'b0);
    wait_rsp(d, er, n);
    chk("post_rd_data", 32'(d), 32'h7F);
    issue(1'b1, 8'h01, 1'b0);
    wait_rsp(d, er, n);
    chk("post_wr_data", 32'(d), VERIFY_ON ? 32'h02 : 32'h01);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
